// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle datapath control FSM:
//   - instruction opcodes (instr[31:26])
//   - 4-bit FSM state encodings (also visible on the debug state port)
//   - ALU B-operand and PC-source mux encodings
//   - bit positions of the one-hot decoded opcode class
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    // FSM states; codes 13-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ANDIEX = 4'd11,
        ST_ANDIWB = 4'd12
    } state_e;

    // ALU B-operand select
    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_IMM2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Bit positions in the one-hot class vector {is_r, is_lw, is_sw, is_beq, is_j, is_andi}
    localparam int CLS_R    = 5;
    localparam int CLS_LW   = 4;
    localparam int CLS_SW   = 3;
    localparam int CLS_BEQ  = 2;
    localparam int CLS_J    = 1;
    localparam int CLS_ANDI = 0;

endpackage

// File: rtl/multicycle_control_opdec.sv
// -----------------------------------------------------------------------------
// mcc_opdec
// Combinational opcode-to-class decoder.
//   opcode_i  [5:0]  instruction opcode
//   class_o   [5:0]  one-hot {is_r, is_lw, is_sw, is_beq, is_j, is_andi}
//   illegal_o        1 when the opcode is not one of the supported ones
// -----------------------------------------------------------------------------
module mcc_opdec
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [5:0] class_o,
    output logic       illegal_o
);

    // Opcode lookup; unknown opcodes leave the class vector empty
    always_comb begin
        class_o   = 6'b000000;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: class_o[CLS_R]    = 1'b1;
            OP_LW:    class_o[CLS_LW]   = 1'b1;
            OP_SW:    class_o[CLS_SW]   = 1'b1;
            OP_BEQ:   class_o[CLS_BEQ]  = 1'b1;
            OP_J:     class_o[CLS_J]    = 1'b1;
            OP_ANDI:  class_o[CLS_ANDI] = 1'b1;
            default:  illegal_o         = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle datapath. Decodes the opcode in DECODE,
// sequences each instruction through 3-5 states and drives the datapath
// enables/muxes plus the ALU-control inputs (aluop1, aluop0, andisignal).
// Also counts retired instructions and flags illegal opcodes.
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode, zero        instr[31:26] (used in DECODE only), ALU zero flag
//   pcen ... andisignal Moore datapath controls (pcen also gated by zero)
//   instr_done          pulse in the last state of every instruction
//   illegal_op          pulse in DECODE for an unsupported opcode
//   retired [CNT_W]     wrapping count of completed instructions
//   state   [4]         current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pcen,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             memtoreg,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsource,
    output logic             aluop1,
    output logic             aluop0,
    output logic             andisignal,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_e             state_q, state_d;
    logic               is_lw_q, is_lw_d;   // LW vs SW, latched in DECODE
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [5:0]         dec_class;
    logic               dec_illegal;
    logic               pcwrite;

    mcc_opdec u_opdec (
        .opcode_i  (opcode),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    // State, latched memory-op kind and retired counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            is_lw_q   <= 1'b0;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            is_lw_q   <= is_lw_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic; the opcode is only looked at in DECODE
    always_comb begin
        state_d = state_q;
        is_lw_d = is_lw_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                is_lw_d = dec_class[CLS_LW];
                if (dec_class[CLS_LW] || dec_class[CLS_SW]) begin
                    state_d = ST_MEMADR;
                end else if (dec_class[CLS_R]) begin
                    state_d = ST_EXEC;
                end else if (dec_class[CLS_BEQ]) begin
                    state_d = ST_BRANCH;
                end else if (dec_class[CLS_J]) begin
                    state_d = ST_JUMP;
                end else if (dec_class[CLS_ANDI]) begin
                    state_d = ST_ANDIEX;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMADR: begin
                if (is_lw_q) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_MEMRD:  state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_RWB;
            ST_RWB:    state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_ANDIEX: state_d = ST_ANDIWB;
            ST_ANDIWB: state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        pcwrite    = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUB_REG;
        pcsource   = PCSRC_ALU;
        aluop1     = 1'b0;
        aluop0     = 1'b0;
        andisignal = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            ST_FETCH: begin
                memread = 1'b1;
                irwrite = 1'b1;
                alusrcb = ALUB_FOUR;
                pcwrite = 1'b1;
            end
            ST_DECODE: alusrcb = ALUB_IMM2;
            ST_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUB_IMM;
            end
            ST_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEMWR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
            end
            ST_EXEC: begin
                alusrca = 1'b1;
                aluop1  = 1'b1;
            end
            ST_RWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alusrca    = 1'b1;
                aluop0     = 1'b1;
                pcsource   = PCSRC_ALUOUT;
                instr_done = 1'b1;
            end
            ST_JUMP: begin
                pcwrite    = 1'b1;
                pcsource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            ST_ANDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = ALUB_IMM;
                andisignal = 1'b1;
            end
            ST_ANDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: pcwrite = 1'b0;
        endcase
    end

    // Retire count advances on the edge that leaves a final state
    always_comb begin
        if (instr_done) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // Branch takes the PC only when the ALU reports equality
    assign pcen       = pcwrite | ((state_q == ST_BRANCH) & zero);
    assign illegal_op = (state_q == ST_DECODE) & dec_illegal;
    assign retired    = retired_q;
    assign state      = state_q;

endmodule
